// File: rtl/pacman_life_manager_pkg.sv
// rtl/pacman_life_manager_pkg.sv - shared game constants for the life manager
// Purpose: FSM state encoding (HUD-visible) and default frame counts / widths.
// Ports: none (package).
package pacman_life_manager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_DYING    = 3'd2,
    ST_RESPAWN  = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam int DEF_LIVES_W        = 3;
  localparam int DEF_INIT_LIVES     = 3;
  localparam int DEF_DEATH_FRAMES   = 90;
  localparam int DEF_RESPAWN_FRAMES = 30;
  localparam int DEF_INVULN_FRAMES  = 120;
  localparam int DEF_TIMER_W        = 8;

endpackage

// File: rtl/pacman_life_manager_if.sv
// rtl/pacman_life_manager_if.sv - game-side bundle between movement/collision logic and the life manager
// Purpose: groups the per-frame inputs and the status/control outputs of the life manager.
// Signals:
//   frame_tick, pacman_is_dead, start          : driven by the game (master)
//   lives, state, freeze, respawn, death_anim,
//   invulnerable, game_over                     : driven by the life manager (slave)
interface pacman_life_manager_if
  import pacman_life_manager_pkg::*;
#(
  parameter int LIVES_W = DEF_LIVES_W
);

  logic               frame_tick;
  logic               pacman_is_dead;
  logic               start;
  logic [LIVES_W-1:0] lives;
  logic [2:0]         state;
  logic               freeze;
  logic               respawn;
  logic               death_anim;
  logic               invulnerable;
  logic               game_over;

  modport master (
    output frame_tick, pacman_is_dead, start,
    input  lives, state, freeze, respawn, death_anim, invulnerable, game_over
  );

  modport slave (
    input  frame_tick, pacman_is_dead, start,
    output lives, state, freeze, respawn, death_anim, invulnerable, game_over
  );

endinterface

// File: rtl/pacman_life_manager_frame_timer.sv
// rtl/pacman_life_manager_frame_timer.sv - frame-tick counter used for phase and invulnerability timing
// Purpose: TIMER_W counter advanced by frame ticks.
//   Up mode   (DOWN=0): i_clear/i_load reset to 0; o_done = i_tick && count == i_limit (i_limit = N-1).
//   Down mode (DOWN=1): i_load loads i_limit; counts down to 0 and holds; o_done = (count == 0).
// Ports: clk, rst_n (async active-low), i_clear, i_load, i_tick, i_limit, o_done.
module pacman_life_manager_frame_timer
  import pacman_life_manager_pkg::*;
#(
  parameter int TIMER_W = DEF_TIMER_W,
  parameter bit DOWN    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_tick,
  input  logic [TIMER_W-1:0] i_limit,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  // Clear beats load beats tick, so a tick landing on a phase entry edge is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= DOWN ? i_limit : '0;
    end else if (i_tick) begin
      if (DOWN) begin
        if (r_count != '0) r_count <= r_count - TIMER_W'(1);
      end else begin
        r_count <= r_count + TIMER_W'(1);
      end
    end
  end

  assign o_done = DOWN ? (r_count == '0) : (i_tick && (r_count == i_limit));

endmodule

// File: rtl/pacman_life_manager.sv
// rtl/pacman_life_manager.sv - life counting and death/respawn/game-over sequencing
// Purpose: IDLE -> PLAY -> DYING -> RESPAWN -> PLAY ... -> GAMEOVER, timed in frame ticks.
// Optional feature: PACMAN_INVULN_EN enables a post-respawn invulnerability window.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pacman_life_manager_if.slave (frame_tick, pacman_is_dead, start in;
//           lives, state, freeze, respawn, death_anim, invulnerable, game_over out)
module pacman_life_manager
  import pacman_life_manager_pkg::*;
#(
  parameter int INIT_LIVES     = DEF_INIT_LIVES,
  parameter int LIVES_W        = DEF_LIVES_W,
  parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
  parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
  parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES,
  parameter int TIMER_W        = DEF_TIMER_W
) (
  input logic                   clk,
  input logic                   rst_n,
  pacman_life_manager_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  logic [LIVES_W-1:0] r_lives;
  logic               r_respawn;

  logic               w_start_game;
  logic               w_kill;
  logic               w_respawn_set;
  logic               w_inv_arm;
  logic               w_phase_done;
  logic               w_phase_clear;
  logic               w_invuln;
  logic [TIMER_W-1:0] w_phase_limit;

  // Only DYING and RESPAWN consume the phase timer's done; elsewhere the count is don't-care.
  assign w_phase_limit = (r_state == ST_DYING) ? TIMER_W'(DEATH_FRAMES - 1)
                                               : TIMER_W'(RESPAWN_FRAMES - 1);
  assign w_phase_clear = (w_next != r_state);

  pacman_life_manager_frame_timer #(
    .TIMER_W (TIMER_W),
    .DOWN    (1'b0)
  ) u_phase_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_phase_clear),
    .i_load  (1'b0),
    .i_tick  (bus.frame_tick),
    .i_limit (w_phase_limit),
    .o_done  (w_phase_done)
  );

`ifdef PACMAN_INVULN_EN
  logic w_inv_expired;

  // Armed only on RESPAWN->PLAY; wiped whenever PLAY is left so a new game starts vulnerable.
  pacman_life_manager_frame_timer #(
    .TIMER_W (TIMER_W),
    .DOWN    (1'b1)
  ) u_inv_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear ((r_state == ST_PLAY) && (w_next != ST_PLAY)),
    .i_load  (w_inv_arm),
    .i_tick  (bus.frame_tick),
    .i_limit (TIMER_W'(INVULN_FRAMES)),
    .o_done  (w_inv_expired)
  );

  assign w_invuln = ~w_inv_expired;
`else
  assign w_invuln = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_start_game  = 1'b0;
    w_kill        = 1'b0;
    w_respawn_set = 1'b0;
    w_inv_arm     = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAMEOVER: begin
        if (bus.start) begin
          w_next        = ST_PLAY;
          w_start_game  = 1'b1;
          w_respawn_set = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bus.pacman_is_dead && !w_invuln) begin
          w_next = ST_DYING;
          w_kill = 1'b1;
        end
      end
      ST_DYING: begin
        if (w_phase_done) begin
          if (r_lives == '0) begin
            w_next = ST_GAMEOVER;
          end else begin
            w_next        = ST_RESPAWN;
            w_respawn_set = 1'b1;
          end
        end
      end
      ST_RESPAWN: begin
        if (w_phase_done) begin
          w_next    = ST_PLAY;
          w_inv_arm = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lives   <= '0;
      r_respawn <= 1'b0;
    end else begin
      r_respawn <= w_respawn_set;
      if (w_start_game) begin
        r_lives <= LIVES_W'(INIT_LIVES);
      end else if (w_kill && (r_lives != '0)) begin
        r_lives <= r_lives - LIVES_W'(1);
      end
    end
  end

  // Status is decoded from registered state only.
  assign bus.lives        = r_lives;
  assign bus.state        = r_state;
  assign bus.freeze       = (r_state != ST_PLAY);
  assign bus.respawn      = r_respawn;
  assign bus.death_anim   = (r_state == ST_DYING);
  assign bus.game_over    = (r_state == ST_GAMEOVER);
  assign bus.invulnerable = w_invuln;

endmodule

// File: doc/pacman_life_manager.md
# pacman_life_manager

Downstream consumer of the collision detector's `pacman_is_dead` flag; owns the game's life/death sequencing. Counts lives and runs a frame-timed state machine: play, death animation, respawn, game over. Drives `freeze` to the movement logic, a one-cycle `respawn` pulse to the position registers, and status to the renderer and score HUD.

## Interface
Parameters:
- `INIT_LIVES`, 3: lives loaded at game start. Must be 1..2^LIVES_W-1.
- `LIVES_W`, 3: width of the lives counter.
- `DEATH_FRAMES`, 90: frame ticks spent in the death animation. Must be ≥1.
- `RESPAWN_FRAMES`, 30: frame ticks of frozen "ready" period after respawn. Must be ≥1.
- `INVULN_FRAMES`, 120: post-respawn invulnerability length in frame ticks. Only used with the macro. Must be ≥1.
- `TIMER_W`, 8: width of the frame timers. Must hold every *_FRAMES value.

Ports:
- `clk`, in, 1: system clock. One clock domain; everything is sampled on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-`clk` pulse per display frame.
- `pacman_is_dead`, in, 1: combinational collision flag from the collision detector.
- `start`, in, 1: level-sampled start/restart request.
- `lives`, out, LIVES_W: remaining lives.
- `state`, out, 3: encoded FSM state, for the HUD.
- `freeze`, out, 1: 1 halts pacman and ghost movement.
- `respawn`, out, 1: one-cycle pulse; reloads pacman and ghost start positions.
- `death_anim`, out, 1: 1 while in DYING.
- `invulnerable`, out, 1: 1 while collisions are being ignored.
- `game_over`, out, 1: 1 while in GAMEOVER.

## Operation
States and behaviour:
- **IDLE**
  - `freeze`=1.
  - `start` → PLAY; load `lives`=INIT_LIVES; pulse `respawn`.
- **PLAY**
  - `freeze`=0.
  - `pacman_is_dead`=1 and not `invulnerable` → DYING.
  - On that same edge, decrement `lives`. The decrement saturates at 0.
- **DYING**
  - `freeze`=1, `death_anim`=1.
  - Stay for DEATH_FRAMES ticks, then:
    - `lives`==0 → GAMEOVER;
    - otherwise → RESPAWN, with `respawn` pulsed on the entry edge.
- **RESPAWN**
  - `freeze`=1.
  - After RESPAWN_FRAMES ticks → PLAY.
  - The invulnerability window is armed on this exit (macro only).
- **GAMEOVER**
  - `freeze`=1, `game_over`=1.
  - `start` → PLAY with the same actions as from IDLE.

Rules that apply in every state:
- `pacman_is_dead` is ignored outside PLAY.
- `start` is ignored in PLAY, DYING and RESPAWN.

Phase timer (`TIMER_W`):
- Clears to 0 on every state entry.
- Increments on `frame_tick`.
- Exits on the edge where `frame_tick`=1 and the count equals N-1. A phase therefore lasts exactly N frame ticks.

Boundary cases:
- `frame_tick` coincident with death in PLAY: death is taken; the tick is not counted toward DYING.
- `start` held high through GAMEOVER exit: one restart only. No effect until the next GAMEOVER/IDLE.
- `lives` is never decremented in any state other than PLAY.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values:
  - `state`=IDLE, `lives`=0, `freeze`=1;
  - `respawn`=0, `death_anim`=0, `invulnerable`=0, `game_over`=0;
  - all timers=0.
- Latency:
  - `pacman_is_dead` high at edge k → `state`=DYING, `freeze`=1 and decremented `lives` visible after edge k.
  - `start` sampled at edge k → `respawn`=1 for the single cycle after edge k only.
- All outputs are registered. None is combinational from any input.

## Configuration
- Macro: `PACMAN_INVULN_EN`.
- **Defined:**
  - On the RESPAWN→PLAY edge, load a dedicated invulnerability counter with INVULN_FRAMES.
  - Decrement it on `frame_tick`; `invulnerable`=1 while it is nonzero.
  - Collisions are ignored while `invulnerable`=1.
  - The counter clears on any exit from PLAY and is not armed on start from IDLE/GAMEOVER.
- **Undefined:**
  - No counter; `invulnerable` is tied to 0.
  - Any collision in PLAY kills immediately.
  - INVULN_FRAMES is unused.

## Structure
- The shared game package holds:
  - state encoding constants (IDLE=0, PLAY=1, DYING=2, RESPAWN=3, GAMEOVER=4);
  - default frame counts and the lives width.
- One sub-module, `_frame_timer`:
  - TIMER_W counter with clear, tick and `done` outputs, where `done` = tick && count==N-1.
  - Instantiated for the phase timer, plus a second instance (down-count mode) for invulnerability when enabled.

## Test plan
Unless stated otherwise, frame ticks are every 4 clk and parameters are DEATH=3, RESPAWN=2, INIT_LIVES=3.
- **Reset during DYING:** deassert `rst_n` → `state`=IDLE, `lives`=0, `freeze`=1, all pulses 0, on the same cycle (async).
- **Start from IDLE:** `start` for one cycle → `state`=PLAY, `lives`=3, `respawn` high exactly one cycle, `freeze`=0.
- **Death in PLAY:** `pacman_is_dead` one cycle → DYING, `lives`=2. After 3 ticks → RESPAWN with a 1-cycle `respawn`. After 2 more ticks → PLAY.
- **Game over:** three deaths → after the final DYING, `game_over`=1, `lives`=0. Extra `pacman_is_dead` leaves `lives` at 0. `start` → PLAY, `lives`=3.
- **Invulnerability, macro defined, INVULN=4:** `pacman_is_dead` held high after respawn → no death for 4 ticks, then DYING on the next cycle.
- **Invulnerability, macro undefined:** same stimulus → DYING one cycle after PLAY entry; `invulnerable` always 0.
- **Ignored inputs:** `pacman_is_dead` high throughout DYING/RESPAWN and `start` pulses during PLAY → no extra decrement, no state change.
